// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: holds PC, fetches words over a req/ack port,
// latches them into IR and hands opcode/operand/flag to the control unit.
module fetch_sequencer #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              flag,
  output logic              exec_valid,
  input  logic              ctrl_done,
  input  logic              ctrl_branch,
  input  logic              ctrl_flag_we,
  input  logic              alu_flag,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              flag_nxt;

  // Memory handshake: mem_req and mem_addr are held stable from the first
  // FETCH cycle until the edge on which mem_ack is sampled high; that edge
  // transfers mem_rdata into IR. mem_ack in any other state is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      pc    <= RESET_PC;
      flag  <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc    <= pc_nxt;
      flag  <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc;
    flag_nxt  = flag;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // Branch decision reads the flag register before any same-cycle write.
        if (ctrl_flag_we) flag_nxt = alu_flag;
        if (ctrl_done) begin
          if (ctrl_branch && flag) pc_nxt = operand;
          else                     pc_nxt = pc + ADDR_W'(1);
          state_nxt = (opcode == HALT_OP) ? HALT : FETCH;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode from registered state so they drop with async reset.
  assign mem_req    = (state == FETCH);
  assign exec_valid = (state == EXEC);
  assign halted     = (state == HALT);
  assign mem_addr   = pc;
  assign opcode     = ir[DATA_W-1 -: 4];
  assign operand    = ir[ADDR_W-1:0];
  assign dbg_state  = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory/control drivers, a PC/flag reference
// model, and a monitor that pops expected fetches and instructions.
module tb_fetch_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;
  logic          flag;
  logic          exec_valid;
  logic          ctrl_done;
  logic          ctrl_branch;
  logic          ctrl_flag_we;
  logic          alu_flag;
  logic          halted;
  logic [AW-1:0] pc;
  logic [1:0]    dbg_state;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .opcode(opcode), .operand(operand), .flag(flag), .exec_valid(exec_valid),
    .ctrl_done(ctrl_done), .ctrl_branch(ctrl_branch), .ctrl_flag_we(ctrl_flag_we),
    .alu_flag(alu_flag), .halted(halted), .pc(pc), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state and scoreboard
  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0]   m_pc;
  logic            m_flag;
  logic            m_halt;
  logic [DW-1:0]   m_ir;
  logic [AW:0]     exp_q[$];
  logic [DW-1:0]   ir_q[$];
  int              n_pass = 0;
  int              n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected DUT event", name);
  endfunction

  // monitor
  logic          req_seen, exe_seen;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_ir;

  always @(negedge clk) begin
    if (!rst_n) begin
      req_seen = 1'b0;
      exe_seen = 1'b0;
    end else begin
      if (mem_req) begin
        if (!req_seen) begin
          if (exp_q.size() == 0) fail_now("fetch_unexpected");
          else begin
            logic [AW:0] e;
            e = exp_q.pop_front();
            cur_addr = e[AW-1:0];
            check("fetch_flag", flag, e[AW]);
          end
        end
        check("fetch_addr", mem_addr, cur_addr);
        check("fetch_pc", pc, cur_addr);
      end
      if (exec_valid) begin
        if (!exe_seen) begin
          if (ir_q.size() == 0) fail_now("exec_unexpected");
          else cur_ir = ir_q.pop_front();
        end
        check("exec_ir", {opcode, operand}, cur_ir);
      end
      req_seen = mem_req;
      exe_seen = exec_valid;
    end
  end

  // driver tasks
  task automatic clear_ctrl();
    ctrl_done = 1'b0; ctrl_branch = 1'b0; ctrl_flag_we = 1'b0; alu_flag = 1'b0;
  endtask

  task automatic reset_checks();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_exec_valid", exec_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc, 12'h000);
    check("rst_ir", {opcode, operand}, 16'h0000);
    check("rst_flag", flag, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'hF0F0;
    clear_ctrl();
    #1;
    reset_checks();
    exp_q.delete();
    ir_q.delete();
    m_pc = 12'h000;
    m_flag = 1'b0;
    m_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    exp_q.push_back({1'b0, 12'h000});
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input int ack_dly, output int waited);
    m_ir = mem[m_pc];
    ir_q.push_back(m_ir);
    waited = 0;
    while (!mem_req && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!mem_req) begin
      fail_now("fetch_timeout");
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      ctrl_done = 1'($urandom); ctrl_branch = 1'($urandom);
      ctrl_flag_we = 1'($urandom); alu_flag = 1'($urandom);
      @(posedge clk); #1;
    end
    clear_ctrl();
    mem_ack = 1'b1;
    mem_rdata = mem[mem_addr];
    @(posedge clk); #1;
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    check("ack_to_exec", {exec_valid, mem_req}, 2'b10);
  endtask

  task automatic do_exec(input bit pre_we, input bit pre_af, input int dly,
                         input bit br, input bit same_we, input bit same_af);
    int t = 0;
    while (!exec_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!exec_valid) begin
      fail_now("exec_timeout");
      return;
    end
    if (pre_we) begin
      ctrl_flag_we = 1'b1; alu_flag = pre_af;
      m_flag = pre_af;
      @(posedge clk); #1;
      clear_ctrl();
    end
    for (int i = 0; i < dly; i++) begin
      ctrl_branch = 1'($urandom); alu_flag = 1'($urandom);
      mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    ctrl_done = 1'b1; ctrl_branch = br; ctrl_flag_we = same_we; alu_flag = same_af;
    if (br && m_flag) m_pc = m_ir[AW-1:0];
    else              m_pc = m_pc + 12'd1;
    if (same_we) m_flag = same_af;
    if (m_ir[15:12] == 4'hF) m_halt = 1'b1;
    else exp_q.push_back({m_flag, m_pc});
    @(posedge clk); #1;
    clear_ctrl();
    check("exec_drop", exec_valid, 1'b0);
    check("after_done", {mem_req, halted}, m_halt ? 2'b01 : 2'b10);
  endtask

  // stimulus
  initial begin
    int w;
    rst_n = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    clear_ctrl();
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    mem[12'h000] = 16'h8005;
    mem[12'h001] = 16'h30A0;
    mem[12'h0A0] = 16'h20B0;
    mem[12'h0A1] = 16'h4123;
    mem[12'h0A2] = 16'h5FFF;
    mem[12'hFFF] = 16'h1234;
    #2;
    do_reset();

    // first fetch latency and sequential step
    do_fetch(0, w);
    check("req_latency", w, 1);
    check("first_opcode", opcode, 4'h8);
    check("first_operand", operand, 12'h005);
    do_exec(0, 0, 0, 0, 0, 0);
    // delayed ack, flag set, taken branch
    do_fetch(3, w);
    do_exec(1, 1, 1, 1, 0, 0);
    // flag cleared, branch not taken
    do_fetch(0, w);
    do_exec(1, 0, 2, 1, 0, 0);
    // same-cycle flag write uses old flag (0): no branch
    do_fetch(1, w);
    do_exec(0, 0, 0, 1, 1, 1);
    // flag now 1: branch to FFF, then wrap to 0
    do_fetch(2, w);
    do_exec(0, 0, 1, 1, 0, 0);
    do_fetch(0, w);
    do_exec(0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 12'h000);

    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom_range(0, 3), w);
      do_exec(1'($urandom), 1'($urandom), $urandom_range(0, 3),
              1'($urandom), 1'($urandom), 1'($urandom));
    end

    // halt: parked for 20 cycles with ignored stimulus
    mem[m_pc] = 16'hF000;
    do_fetch(1, w);
    do_exec(0, 0, 2, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      ctrl_done = 1'($urandom); ctrl_branch = 1'($urandom);
      ctrl_flag_we = 1'($urandom); alu_flag = 1'($urandom);
      @(posedge clk); #1;
      check("halt_outputs", {halted, mem_req, exec_valid}, 3'b100);
      check("halt_pc", pc, m_pc);
      check("halt_flag", flag, m_flag);
      check("halt_opcode", opcode, 4'hF);
    end
    mem_ack = 1'b0;
    clear_ctrl();
    do_reset();
    do_fetch(0, w);
    do_exec(1, 1, 0, 0, 0, 0);

    // reset in the middle of a fetch with an ack arriving
    w = 0;
    while (!mem_req && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    check("midfetch_req_before", mem_req, 1'b1);
    do_reset();
    do_fetch(2, w);
    do_exec(0, 0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("ir_q_drained", ir_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
